// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: turns an AA 55 type len_hi len_lo payload [checksum] byte stream into command strobes (CMD_CHECKSUM_EN adds the checksum byte).
// Latency: cmd_start 1 cycle after cmd_ready seen in START, cmd_data_valid 1 cycle after each accepted byte, cmd_done 1 cycle after the last of those.
// Backpressure: in_ready follows cmd_ready in PAYLOAD, is 0 in START/DONE and 1 elsewhere; an inter-byte timeout counts only while in_ready is high.
module cmd_frame_parser #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int MAX_LEN        = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  cmd_type,
  output logic [15:0] cmd_length,
  output logic [7:0]  cmd_data,
  output logic [15:0] cmd_data_index,
  output logic        cmd_start,
  output logic        cmd_data_valid,
  output logic        cmd_done,
  output logic        cmd_error,
  input  logic        cmd_ready
);

  localparam logic [15:0] LP_MAX_LEN  = 16'(MAX_LEN);
  localparam logic [31:0] LP_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_SYNC0, S_SYNC1, S_TYPE, S_LEN_H, S_LEN_L, S_START, S_PAYLOAD, S_CHECK, S_DONE
  } state_t;

`ifdef CMD_CHECKSUM_EN
  localparam state_t LP_AFTER_DATA = S_CHECK;
`else
  localparam state_t LP_AFTER_DATA = S_DONE;
`endif

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_type_rx, r_len_hi;
  logic [15:0] r_len_rx, r_idx;
  logic [31:0] r_tmo_cnt;
  logic [7:0]  r_cmd_type, r_cmd_data;
  logic [15:0] r_cmd_length, r_cmd_index;
  logic        r_start, r_dvld, r_done, r_err;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]  r_sum;
`endif

  logic        w_in_ready, w_acc, w_tmo;
  logic        w_start_set, w_err_set, w_done_set;
  logic [15:0] w_len;

  assign w_in_ready = (r_state == S_START || r_state == S_DONE) ? 1'b0 :
                      (r_state == S_PAYLOAD) ? cmd_ready : 1'b1;
  assign w_acc      = in_valid & w_in_ready;
  assign w_len      = {r_len_hi, in_data};
  // Idle cycles with the input open run the timer; stalls caused by the handler do not.
  assign w_tmo      = (r_state != S_SYNC0) && w_in_ready && !w_acc && (r_tmo_cnt >= LP_TMO_LAST);

  assign in_ready       = w_in_ready;
  assign cmd_type       = r_cmd_type;
  assign cmd_length     = r_cmd_length;
  assign cmd_data       = r_cmd_data;
  assign cmd_data_index = r_cmd_index;
  assign cmd_start      = r_start;
  assign cmd_data_valid = r_dvld;
  assign cmd_done       = r_done;
  assign cmd_error      = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SYNC0;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and the strobe requests that go with each transition.
  always_comb begin
    w_state_nxt = r_state;
    w_start_set = 1'b0;
    w_err_set   = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      S_SYNC0: if (w_acc && in_data == 8'hAA) w_state_nxt = S_SYNC1;
      S_SYNC1: if (w_acc) begin
        if (in_data == 8'h55)      w_state_nxt = S_TYPE;
        else if (in_data == 8'hAA) w_state_nxt = S_SYNC1;
        else                       w_state_nxt = S_SYNC0;
      end
      S_TYPE:  if (w_acc) w_state_nxt = S_LEN_H;
      S_LEN_H: if (w_acc) w_state_nxt = S_LEN_L;
      S_LEN_L: if (w_acc) begin
        if (w_len > LP_MAX_LEN) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_SYNC0;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_START: if (cmd_ready) begin
        w_start_set = 1'b1;
        w_state_nxt = (r_len_rx == 16'd0) ? LP_AFTER_DATA : S_PAYLOAD;
      end
      S_PAYLOAD: if (w_acc && r_idx == r_len_rx - 16'd1) w_state_nxt = LP_AFTER_DATA;
      S_CHECK: begin
`ifdef CMD_CHECKSUM_EN
        if (w_acc) begin
          if (in_data == r_sum) begin
            w_state_nxt = S_DONE;
          end else begin
            w_err_set   = 1'b1;
            w_state_nxt = S_SYNC0;
          end
        end
`else
        w_state_nxt = S_SYNC0;
`endif
      end
      S_DONE: begin
        w_done_set  = 1'b1;
        w_state_nxt = S_SYNC0;
      end
      default: w_state_nxt = S_SYNC0;
    endcase
    // Timeout wins; it is only reported once the handler has seen cmd_start.
    if (w_tmo) begin
      w_state_nxt = S_SYNC0;
      w_err_set   = (r_state == S_PAYLOAD || r_state == S_CHECK);
    end
  end

  // Header capture, payload delivery, strobes and the inter-byte timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type_rx    <= '0;
      r_len_hi     <= '0;
      r_len_rx     <= '0;
      r_idx        <= '0;
      r_tmo_cnt    <= '0;
      r_cmd_type   <= '0;
      r_cmd_length <= '0;
      r_cmd_data   <= '0;
      r_cmd_index  <= '0;
      r_start      <= 1'b0;
      r_dvld       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_start <= w_start_set;
      r_err   <= w_err_set;
      r_done  <= w_done_set;
      r_dvld  <= 1'b0;
      if (r_state == S_SYNC0 || w_acc) r_tmo_cnt <= '0;
      else if (w_tmo)                  r_tmo_cnt <= '0;
      else if (w_in_ready)             r_tmo_cnt <= r_tmo_cnt + 32'd1;
      if (r_state == S_TYPE  && w_acc) r_type_rx <= in_data;
      if (r_state == S_LEN_H && w_acc) r_len_hi  <= in_data;
      if (r_state == S_LEN_L && w_acc) r_len_rx  <= w_len;
      if (w_start_set) begin
        r_cmd_type   <= r_type_rx;
        r_cmd_length <= r_len_rx;
        r_idx        <= '0;
      end
      if (r_state == S_PAYLOAD && w_acc) begin
        r_dvld      <= 1'b1;
        r_cmd_data  <= in_data;
        r_cmd_index <= r_idx;
        r_idx       <= r_idx + 16'd1;
      end
    end
  end

`ifdef CMD_CHECKSUM_EN
  // Running sum of type, length and payload; restarted on each sync word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (w_acc) begin
      if (r_state == S_SYNC1)
        r_sum <= '0;
      else if (r_state == S_TYPE || r_state == S_LEN_H || r_state == S_LEN_L || r_state == S_PAYLOAD)
        r_sum <= r_sum + in_data;
    end
  end
`endif

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Scoreboard bench for cmd_frame_parser: expected strobes are queued as bytes are driven
// and popped when the DUT pulses cmd_start/cmd_data_valid/cmd_done/cmd_error.
// A short TIMEOUT_CYCLES keeps the stall scenarios quick.
`timescale 1ns/1ps
module tb_cmd_frame_parser;
  localparam int TMO  = 40;
  localparam int MAXL = 1024;
  localparam int K_START = 1, K_DATA = 2, K_DONE = 3, K_ERR = 4;

  typedef struct { int kind; int a; int b; } evt_t;

  logic        clk, rst_n;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  cmd_type, cmd_data;
  logic [15:0] cmd_length, cmd_data_index;
  logic        cmd_start, cmd_data_valid, cmd_done, cmd_error, cmd_ready;

  evt_t       exp_q[$];
  logic [7:0] pl[$];
  int n_checks = 0, n_fail = 0;
  int stall_cnt = 0;
  bit rand_rdy = 0;
  int cyc = 0, last_evt_cyc = 0;
  int cur_type = 0, cur_len = 0;

  cmd_frame_parser #(.TIMEOUT_CYCLES(TMO), .MAX_LEN(MAXL)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cmd_type(cmd_type), .cmd_length(cmd_length), .cmd_data(cmd_data),
    .cmd_data_index(cmd_data_index), .cmd_start(cmd_start), .cmd_data_valid(cmd_data_valid),
    .cmd_done(cmd_done), .cmd_error(cmd_error), .cmd_ready(cmd_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input int k, input int a, input int b);
    evt_t e;
    e.kind = k; e.a = a; e.b = b;
    exp_q.push_back(e);
  endfunction

  // Handler side: cmd_ready is 1 unless a stall or random mode is active.
  initial begin
    cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        cmd_ready = 1'b0;
        stall_cnt--;
      end else if (rand_rdy) begin
        cmd_ready = 1'($urandom_range(0, 1));
      end else begin
        cmd_ready = 1'b1;
      end
    end
  end

  // Monitor: compare every strobe against the head of the scoreboard.
  initial begin
    int   n, kind;
    evt_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        n = int'(cmd_start) + int'(cmd_data_valid) + int'(cmd_done) + int'(cmd_error);
        if (n > 0) begin
          if (n > 1) check_eq("pulse_exclusive", n, 1);
          kind = cmd_start ? K_START : cmd_data_valid ? K_DATA : cmd_done ? K_DONE : K_ERR;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_event", kind, 0);
          end else begin
            e = exp_q.pop_front();
            check_eq("event_kind", kind, e.kind);
            if (kind == K_START && e.kind == K_START) begin
              check_eq("cmd_type", int'(cmd_type), e.a);
              check_eq("cmd_length", int'(cmd_length), e.b);
              cur_type = e.a;
              cur_len  = e.b;
            end
            if (kind == K_DATA && e.kind == K_DATA) begin
              check_eq("cmd_data", int'(cmd_data), e.a);
              check_eq("cmd_data_index", int'(cmd_data_index), e.b);
              check_eq("type_hold", int'(cmd_type), cur_type);
              check_eq("length_hold", int'(cmd_length), cur_len);
            end
`ifndef CMD_CHECKSUM_EN
            if (kind == K_DONE) check_eq("done_latency", cyc - last_evt_cyc, 1);
`endif
          end
          last_evt_cyc = cyc;
        end
      end
    end
  end

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) check_eq("in_ready_wait", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] typ, input logic [15:0] len);
    send_byte(8'hAA);
    send_byte(8'h55);
    send_byte(typ);
    send_byte(len[15:8]);
    push(K_START, int'(typ), int'(len));
    send_byte(len[7:0]);
  endtask

  // Complete frame from pl[]; oversize lengths expect only cmd_error.
  task automatic send_frame(input logic [7:0] typ, input logic [15:0] len);
    logic [7:0] sum;
    sum = typ + len[15:8] + len[7:0];
    if (int'(len) > MAXL) begin
      send_byte(8'hAA); send_byte(8'h55); send_byte(typ); send_byte(len[15:8]);
      send_byte(len[7:0]);
      push(K_ERR, 0, 0);
    end else begin
      send_hdr(typ, len);
      for (int i = 0; i < int'(len); i++) begin
        push(K_DATA, int'(pl[i]), i);
        send_byte(pl[i]);
        sum = sum + pl[i];
      end
`ifdef CMD_CHECKSUM_EN
      send_byte(sum);
`endif
      push(K_DONE, 0, 0);
    end
  endtask

  task automatic drain(input string tag);
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic chk_cleared(input string pfx);
    check_eq({pfx, "_in_ready"}, int'(in_ready), 1);
    check_eq({pfx, "_start"}, int'(cmd_start), 0);
    check_eq({pfx, "_dvld"}, int'(cmd_data_valid), 0);
    check_eq({pfx, "_done"}, int'(cmd_done), 0);
    check_eq({pfx, "_error"}, int'(cmd_error), 0);
    check_eq({pfx, "_type"}, int'(cmd_type), 0);
    check_eq({pfx, "_length"}, int'(cmd_length), 0);
    check_eq({pfx, "_data"}, int'(cmd_data), 0);
    check_eq({pfx, "_index"}, int'(cmd_data_index), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    #12;
    chk_cleared("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reference frame: type FD, nine payload bytes.
    pl = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    send_frame(8'hFD, 16'd9);
    drain("frame_fd_drain");

    // Leading garbage and a repeated AA before the sync word; zero length.
    send_byte(8'h12); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'hFE); send_byte(8'h00);
    push(K_START, 'hFE, 0);
    send_byte(8'h00);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'hFE);
`endif
    push(K_DONE, 0, 0);
    drain("garbage_len0_drain");

    // Oversize length rejected; exactly MAX_LEN accepted.
    send_frame(8'h10, 16'h0401);
    drain("oversize_drain");
    pl.delete();
    for (int i = 0; i < MAXL; i++) pl.push_back(8'(i * 7));
    send_frame(8'h11, 16'(MAXL));
    drain("maxlen_drain");

`ifdef CMD_CHECKSUM_EN
    // Checksum good then bad.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFD); send_byte(8'h00);
    push(K_START, 'hFD, 1);
    send_byte(8'h01);
    push(K_DATA, 'h03, 0);
    send_byte(8'h03); send_byte(8'h01);
    push(K_DONE, 0, 0);
    drain("cks_good_drain");
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFD); send_byte(8'h00);
    push(K_START, 'hFD, 1);
    send_byte(8'h01);
    push(K_DATA, 'h03, 0);
    send_byte(8'h03); send_byte(8'h02);
    push(K_ERR, 0, 0);
    drain("cks_bad_drain");
`endif

    // Handler stall longer than the timeout with in_valid held: no error, no loss.
    pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_hdr(8'h21, 16'd5);
    for (int i = 0; i < 2; i++) begin
      push(K_DATA, int'(pl[i]), i);
      send_byte(pl[i]);
    end
    stall_cnt = TMO + 20;
    fork
      begin
        for (int i = 2; i < 5; i++) begin
          push(K_DATA, int'(pl[i]), i);
          send_byte(pl[i]);
        end
        push(K_DONE, 0, 0);
      end
      begin
        repeat (3) @(negedge clk);
        check_eq("stall_in_ready", int'(in_ready), 0);
      end
    join
    drain("stall_drain");

    // Random handler readiness over a longer frame.
    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'($urandom_range(0, 255)));
    rand_rdy = 1'b1;
    send_frame(8'h5A, 16'd16);
    drain("random_rdy_drain");
    rand_rdy = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Source stalls after the third payload byte: error, then back in sync.
    pl = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    send_hdr(8'h44, 16'd6);
    for (int i = 0; i < 3; i++) begin
      push(K_DATA, int'(pl[i]), i);
      send_byte(pl[i]);
    end
    push(K_ERR, 0, 0);
    repeat (TMO + 10) @(posedge clk); #1;
    drain("tmo_payload_drain");
    pl = '{8'h77, 8'h78};
    send_frame(8'h45, 16'd2);
    drain("tmo_resync_drain");

    // Source stalls after len_hi: silent drop, next frame parsed from sync.
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h00);
    repeat (TMO + 10) @(posedge clk); #1;
    drain("tmo_silent_drain");
    pl = '{8'h90, 8'h91, 8'h92};
    send_frame(8'h22, 16'd3);
    drain("tmo_hdr_resync_drain");

    // Reset mid-payload: outputs clear at once, no done or error afterwards.
    pl = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    send_hdr(8'h33, 16'd4);
    for (int i = 0; i < 2; i++) begin
      push(K_DATA, int'(pl[i]), i);
      send_byte(pl[i]);
    end
    drain("pre_reset_drain");
    #2 rst_n = 1'b0;
    #1 chk_cleared("midreset");
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (TMO + 10) @(posedge clk); #1;
    drain("post_reset_quiet");
    pl = '{8'hE1};
    send_frame(8'h66, 16'd1);
    drain("post_reset_frame");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
